vga_scan_fetch: RTL and testbench
=================================

VGA_SCAN_FETCH -- requirements
Module: vga_scan_fetch

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal front porch/sync/back porch in clocks.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, meaning vertical timing in lines.
REQ-004 SHALL have parameter SYNC_POL, default 0, meaning active level of hs/vs (0 = active-low).
REQ-005 SHALL have parameter MEM_LAT, default 1, legal 1..4, meaning clocks from mem_en/mem_addr registered to mem_data valid.
REQ-006 SHALL have parameters ADDR_W/DATA_W/STRIDE, defaults 19/16/1024, meaning address width, memory data width, and words per framebuffer line.
REQ-007 SHALL have port clk, input, 1, pixel clock; one clock only.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port scale_i, input, 2, scale mode (0 = 1x, 1 = 2x, 2 = 4x, 3 = treated as 1x).
REQ-010 SHALL have port fb_base, input, ADDR_W, framebuffer base word address.
REQ-011 SHALL have port mem_data, input, DATA_W, read data; rgb uses bits [11:0].
REQ-012 SHALL have ports mem_en (output, 1) and mem_addr (output, ADDR_W), registered read request.
REQ-013 SHALL have ports hs, vs, de (outputs, 1 each) and rgb (output, 12), plus frame_start (output, 1), a one-clock pulse.

Function
REQ-014 SHALL run hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1, where totals are the parameter sums; vcnt advances when hcnt wraps. Order per axis: active, front porch, sync, back porch.
REQ-015 SHALL assert raw hsync for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on vcnt. Raw active = hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-016 SHALL latch fb_base and scale (s) only at hcnt=0,vcnt=0; mid-frame changes have no effect until the next frame.
REQ-017 SHALL keep a line-base register lb: load fb_base at frame start; at each hcnt wrap with vcnt<V_ACTIVE, add STRIDE when (vcnt+1) mod 2^s == 0. No multiplier.
REQ-018 SHALL register mem_addr = (lb + (hcnt>>s)) mod 2^ADDR_W and mem_en = raw active and (hcnt mod 2^s == 0), one clock after the counter value.
REQ-019 SHALL sample mem_data MEM_LAT clocks after mem_en and load rgb from it one clock later; between fetches rgb holds its value, so each source pixel spans 2^s clocks.
REQ-020 SHALL delay hs, vs and de by D = MEM_LAT+2 clocks from the counters, so de, hs, vs and rgb are mutually aligned.
REQ-021 SHALL force rgb to 0 whenever the aligned de is 0.
REQ-022 SHALL drive hs/vs at SYNC_POL while the delayed sync is active, else at ~SYNC_POL.
REQ-023 SHALL pulse frame_start for one clock, aligned with the first de of each frame (counter 0,0 delayed D).

Reset
REQ-024 SHALL, while rst is high, immediately clear hcnt, vcnt, lb, latched s, mem_en, mem_addr, de, rgb and frame_start to 0, and set hs/vs to ~SYNC_POL.
REQ-025 SHALL, after rst is released, start a frame at hcnt=0,vcnt=0 and latch fb_base/scale_i on that first clock.
REQ-026 SHALL, when rst is asserted mid-frame, discard in-flight pipeline contents; no stale pixel appears after release.

Structure
REQ-027 SHALL take default timing constants from the shared vga_parameter header; totals and D are local constants.
REQ-028 SHALL use one sub-module, vga_delay_line (width, depth parameters, async active-high reset), for the hs/vs/de/frame_start alignment.

Verification
REQ-029 Reset release, scale 0, base 0, MEM_LAT 1, memory returns addr[11:0] -> de first high at clock 3; rgb = 0x000..0x27F on line 0; line 1 starts at addr 1024.
REQ-030 Free-run one frame -> hs active for 96 clocks starting 659 clocks after line start; vs active for 2 lines starting at line 490; frame period 800x525 clocks.
REQ-031 scale_i = 1 -> mem_en every other clock; line 0 and line 1 both read addr 0..319; line 2 reads from 1024; each rgb value held 2 clocks.
REQ-032 fb_base changed 0 -> 0x40000 mid-frame -> current frame addresses unchanged; next frame's first mem_addr = 0x40000.
REQ-033 MEM_LAT = 3 build -> D = 5; rgb is still aligned with de and carries the matching addr[11:0] at every pixel.
REQ-034 rst pulsed at line 100, hcnt 300 -> all outputs at reset values within the same clock; the frame restarts from addr fb_base with frame_start D clocks after release.

Source files
------------

// File: rtl/vga_scan_fetch_pkg.sv
// Shared VGA timing defaults and scale helpers for the scan/fetch block.
package vga_scan_fetch_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Scale code 3 is reserved and behaves like 1x.
  function automatic logic [1:0] scale_norm(input logic [1:0] sc);
    return (sc == 2'd3) ? 2'd0 : sc;
  endfunction

  function automatic logic [2:0] scale_mask(input logic [1:0] s);
    return 3'((4'd1 << s) - 4'd1);
  endfunction

endpackage

// File: rtl/vga_scan_fetch_delay_line.sv
// Fixed-depth shift register used to align sync/enable flags with pixel data.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int SR_W = WIDTH * DEPTH;

  // Newest sample enters at the low end, oldest leaves at the top.
  logic [SR_W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= SR_W'({sr, din});
  end

  assign dout = sr[SR_W-1 -: WIDTH];

endmodule

// File: rtl/vga_scan_fetch.sv
// VGA timing generator that fetches framebuffer words and emits aligned
// hs/vs/de/rgb with optional 2x/4x pixel replication.
module vga_scan_fetch
  import vga_scan_fetch_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int MEM_LAT  = 1,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 16,
  parameter int STRIDE   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        scale_i,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [11:0]       rgb,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int D       = MEM_LAT + 2;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0]      hcnt;
  logic [VW-1:0]      vcnt;
  logic [VW-1:0]      vnext;
  logic [1:0]         s_reg;
  logic [1:0]         s_eff;
  logic [ADDR_W-1:0]  lb;
  logic [ADDR_W-1:0]  lb_eff;
  logic               frame_first;
  logic               h_wrap;
  logic               line_step;
  logic               raw_active;
  logic               raw_hs;
  logic               raw_vs;
  logic [MEM_LAT-1:0] fetch_sr;
  logic [11:0]        rgb_reg;
  logic [3:0]         dl_in;
  logic [3:0]         dl_out;

  assign frame_first = (hcnt == '0) && (vcnt == '0);
  assign h_wrap      = (hcnt == HW'(H_TOTAL - 1));
  assign vnext       = vcnt + 1'b1;
  assign raw_active  = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  assign raw_hs      = (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign raw_vs      = (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));

  // On the frame's first clock the latched copies are not yet valid, so the
  // request is built straight from the inputs being latched.
  assign s_eff     = frame_first ? scale_norm(scale_i) : s_reg;
  assign lb_eff    = frame_first ? fb_base : lb;
  assign line_step = ((vnext & VW'(scale_mask(s_reg))) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt     <= '0;
      vcnt     <= '0;
      s_reg    <= '0;
      lb       <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vnext;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
      if (frame_first) begin
        s_reg <= scale_norm(scale_i);
        lb    <= fb_base;
      end else if (h_wrap && (vcnt < VW'(V_ACTIVE)) && line_step) begin
        lb <= lb + ADDR_W'(STRIDE);
      end
      mem_en   <= raw_active && ((hcnt & HW'(scale_mask(s_eff))) == '0);
      mem_addr <= lb_eff + ADDR_W'(hcnt >> s_eff);
    end
  end

  // fetch_sr[k] marks a request issued k+1 clocks ago; the top bit is the
  // clock on which mem_data holds that request's word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_sr <= '0;
      rgb_reg  <= '0;
    end else begin
      fetch_sr <= MEM_LAT'({fetch_sr, mem_en});
      if (fetch_sr[MEM_LAT-1]) rgb_reg <= mem_data[11:0];
    end
  end

  generate
    if (DATA_W > 12) begin : g_unused
      logic unused_bits;
      assign unused_bits = ^mem_data[DATA_W-1:12];
    end
  endgenerate

  assign dl_in = {frame_first, raw_active, raw_hs, raw_vs};

  vga_delay_line #(
    .WIDTH(4),
    .DEPTH(D)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .din (dl_in),
    .dout(dl_out)
  );

  assign frame_start = dl_out[3];
  assign de          = dl_out[2];
  assign hs          = dl_out[1] ? SYNC_POL : ~SYNC_POL;
  assign vs          = dl_out[0] ? SYNC_POL : ~SYNC_POL;
  assign rgb         = de ? rgb_reg : 12'h000;

endmodule

// File: tb/tb_vga_scan_fetch.sv
// Scoreboard bench: two instances (MEM_LAT 1 and 3) on a shrunken raster,
// expected outputs queued per counter position and compared D clocks later.
module tb_vga_scan_fetch;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int STR = 32;
  localparam int AW = 19;
  localparam int D1 = 3;
  localparam int D3 = 5;
  localparam logic [15:0] IDLE = 16'h6000;  // de=0 hs=1 vs=1 fs=0 rgb=0

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    scale_i;
  logic [AW-1:0] fb_base;

  logic [15:0]   mem_data1, mem_data3;
  logic          mem_en1, mem_en3;
  logic [AW-1:0] mem_addr1, mem_addr3;
  logic          hs1, vs1, de1, fs1, hs3, vs3, de3, fs3;
  logic [11:0]   rgb1, rgb3;

  always #5 clk = ~clk;

  vga_scan_fetch #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .MEM_LAT(1), .ADDR_W(AW), .DATA_W(16), .STRIDE(STR)
  ) u_dut1 (
    .clk(clk), .rst(rst), .scale_i(scale_i), .fb_base(fb_base),
    .mem_data(mem_data1), .mem_en(mem_en1), .mem_addr(mem_addr1),
    .hs(hs1), .vs(vs1), .de(de1), .rgb(rgb1), .frame_start(fs1)
  );

  vga_scan_fetch #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .MEM_LAT(3), .ADDR_W(AW), .DATA_W(16), .STRIDE(STR)
  ) u_dut3 (
    .clk(clk), .rst(rst), .scale_i(scale_i), .fb_base(fb_base),
    .mem_data(mem_data3), .mem_en(mem_en3), .mem_addr(mem_addr3),
    .hs(hs3), .vs(vs3), .de(de3), .rgb(rgb3), .frame_start(fs3)
  );

  // Memories return addr[11:0], MEM_LAT clocks after the request.
  logic [AW-1:0] m1_q;
  logic [AW-1:0] m3_q [0:2];
  always @(posedge clk) begin
    m1_q    <= mem_addr1;
    m3_q[0] <= mem_addr3;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign mem_data1 = {4'h0, m1_q[11:0]};
  assign mem_data3 = {4'h0, m3_q[2][11:0]};

  int total = 0;
  int bad   = 0;

  logic [15:0]   q1[$];
  logic [15:0]   q3[$];
  int            mh, mv, ms;
  logic [AW-1:0] mbase;
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  int            cyc;
  int            last_fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at cycle %0d h=%0d v=%0d: observed=%h expected=%h", tag, cyc, mh, mv, obs, exp);
    end
  endtask

  task automatic tick();
    logic [15:0]   e;
    logic [AW-1:0] a;
    logic          act, hsr, vsr;
    @(negedge clk);
    if (rst) begin
      chk("rst_out1", {16'h0, de1, hs1, vs1, fs1, rgb1}, {16'h0, IDLE});
      chk("rst_out3", {16'h0, de3, hs3, vs3, fs3, rgb3}, {16'h0, IDLE});
      chk("rst_mem1", {12'h0, mem_en1, mem_addr1}, 32'h0);
      chk("rst_mem3", {12'h0, mem_en3, mem_addr3}, 32'h0);
      mh = 0; mv = 0; cyc = 0; last_fs = -1;
      exp_en = 1'b0; exp_addr = '0;
      q1.delete(); q3.delete();
      for (int i = 0; i < D1; i++) q1.push_back(IDLE);
      for (int i = 0; i < D3; i++) q3.push_back(IDLE);
    end else begin
      // Request registered from the previous counter position.
      chk("mem_en1", {31'h0, mem_en1}, {31'h0, exp_en});
      chk("mem_en3", {31'h0, mem_en3}, {31'h0, exp_en});
      if (exp_en) begin
        chk("mem_addr1", {13'h0, mem_addr1}, {13'h0, exp_addr});
        chk("mem_addr3", {13'h0, mem_addr3}, {13'h0, exp_addr});
      end
      if (mh == 0 && mv == 0) begin
        mbase = fb_base;
        ms    = (scale_i == 2'd3) ? 0 : int'(scale_i);
      end
      a   = mbase + AW'((mv >> ms) * STR) + AW'(mh >> ms);
      act = (mh < HA) && (mv < VA);
      hsr = (mh >= HA + HF) && (mh < HA + HF + HS);
      vsr = (mv >= VA + VF) && (mv < VA + VF + VS);
      e   = {act, ~hsr, ~vsr, (mh == 0 && mv == 0), act ? a[11:0] : 12'h000};
      exp_en   = act && ((mh % (1 << ms)) == 0);
      exp_addr = a;
      q1.push_back(e);
      q3.push_back(e);
      chk("pix1", {16'h0, de1, hs1, vs1, fs1, rgb1}, {16'h0, q1.pop_front()});
      chk("pix3", {16'h0, de3, hs3, vs3, fs3, rgb3}, {16'h0, q3.pop_front()});
      if (fs1) begin
        if (last_fs >= 0) chk("frame_period", cyc - last_fs, HT * VT);
        last_fs = cyc;
      end
      $display("cyc=%0d h=%0d v=%0d de=%0b hs=%0b vs=%0b rgb1=%h rgb3=%h", cyc, mh, mv, de1, hs1, vs1, rgb1, rgb3);
      cyc++;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; scale_i = 2'd0; fb_base = '0;
    repeat (3) tick();

    // 1x from base 0 for a full frame, then into the next one.
    rst = 1'b0;
    repeat (HT * VT + 30) tick();

    // Mid-frame base/scale change: applies from the next frame only.
    fb_base = 19'h40000; scale_i = 2'd1;
    for (int i = 0; i < 2 * HT * VT && !(mh == 0 && mv == 0); i++) tick();
    repeat (HT * VT) tick();

    // 4x with an address that wraps past 2^ADDR_W.
    fb_base = 19'h7FFF0; scale_i = 2'd2;
    repeat (HT * VT) tick();

    // Reserved scale code behaves as 1x.
    fb_base = 19'h00100; scale_i = 2'd3;
    repeat (HT * VT) tick();

    // Reset mid-line, then restart from a new base.
    for (int i = 0; i < 2 * HT * VT && !(mv == 3 && mh == 7); i++) tick();
    rst = 1'b1; fb_base = 19'h00200; scale_i = 2'd0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (HT * VT + 10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
